// File: rtl/song_seq_pkg.sv
// Shared definitions for the song sequencer: packed entry layout, FSM states
// and the rest-note value.
package song_seq_pkg;

    localparam int ENTRY_W  = 16;
    localparam int ADV_BIT  = 15;
    localparam int NOTE_W   = 6;
    localparam int NOTE_LSB = 9;
    localparam int DUR_W    = 6;
    localparam int DUR_LSB  = 3;
    localparam int META_W   = 3;
    localparam int META_LSB = 0;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_DECODE,
        ST_WAIT_BEAT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/song_sequencer_beat_counter.sv
// Loadable down-counter of beat ticks used to time advance entries.
// A load takes priority; hold freezes the count while the song is paused.
module beat_counter
    import song_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             beat,
    input  logic             hold,
    output logic [DUR_W-1:0] count,
    output logic             zero
);

    logic [DUR_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (beat && !hold && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/song_sequencer.sv
// Multi-song note sequencer: fetches packed entries from a 1-cycle-latency
// song memory, dispatches note events round-robin to voices, waits on beats.
module song_sequencer
    import song_seq_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int SONG_BITS  = 2,
    parameter int ADDR_BITS  = 7,
    parameter bit LOOP       = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           play,
    input  logic [SONG_BITS-1:0]           song_sel,
    input  logic                           beat,
    output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
    input  logic [ENTRY_W-1:0]             rom_dout,
    output logic [NUM_VOICES-1:0]          voice_load,
    output logic [NOTE_W-1:0]              voice_note,
    output logic [DUR_W-1:0]               voice_dur,
    output logic [META_W-1:0]              voice_meta,
    output logic                           playing,
    output logic                           song_done
);

    localparam int VP_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    seq_state_t state_reg, state_next;

    logic [SONG_BITS-1:0]  song_reg;
    logic [ADDR_BITS-1:0]  index_reg;
    logic [VP_W-1:0]       vptr_reg, vptr_next;
    logic [NUM_VOICES-1:0] voice_load_reg, voice_load_next;
    logic [NOTE_W-1:0]     voice_note_reg;
    logic [DUR_W-1:0]      voice_dur_reg;
    logic [META_W-1:0]     voice_meta_reg;
    logic                  playing_reg;
    logic                  song_done_reg;

    logic                  entry_adv;
    logic [NOTE_W-1:0]     entry_note;
    logic [DUR_W-1:0]      entry_dur;
    logic [META_W-1:0]     entry_meta;

    logic                  step;
    logic                  index_last;
    logic                  load_note;
    logic                  cnt_load;
    logic                  cnt_beat;
    logic [DUR_W-1:0]      cnt_count;
    logic                  cnt_zero;

    assign entry_adv  = rom_dout[ADV_BIT];
    assign entry_note = rom_dout[NOTE_LSB +: NOTE_W];
    assign entry_dur  = rom_dout[DUR_LSB +: DUR_W];
    assign entry_meta = rom_dout[META_LSB +: META_W];
    assign index_last = (index_reg == {ADDR_BITS{1'b1}});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pausing in WAIT_DATA/DECODE parks the FSM in FETCH so that the read is
    // re-issued on resume; the entry in flight before the pause is dropped.
    always_comb begin
        state_next = state_reg;
        step       = 1'b0;
        case (state_reg)
            ST_IDLE:      if (play) state_next = ST_FETCH;
            ST_FETCH:     if (play) state_next = ST_WAIT_DATA;
            ST_WAIT_DATA: state_next = play ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (!play) begin
                    state_next = ST_FETCH;
                end else if (!entry_adv || (entry_dur == '0)) begin
                    step = 1'b1;
                end else begin
                    state_next = ST_WAIT_BEAT;
                end
            end
            ST_WAIT_BEAT: begin
                if (play && (cnt_zero || (beat && (cnt_count == DUR_W'(1))))) begin
                    step = 1'b1;
                end
            end
            ST_DONE:      if (!play) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
        if (step) begin
            state_next = (index_last && !LOOP) ? ST_DONE : ST_FETCH;
        end
    end

    always_comb begin
        load_note = (state_reg == ST_DECODE) && play && !entry_adv;
        cnt_load  = (state_reg == ST_DECODE) && play && entry_adv && (entry_dur != '0);
        cnt_beat  = (state_reg == ST_WAIT_BEAT) && beat;
    end

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_load
        assign voice_load_next[gi] = load_note && (vptr_reg == VP_W'(gi));
    end

    assign vptr_next = (vptr_reg == VP_W'(NUM_VOICES - 1)) ? '0 : vptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            song_reg       <= '0;
            index_reg      <= '0;
            vptr_reg       <= '0;
            voice_load_reg <= '0;
            voice_note_reg <= REST_NOTE;
            voice_dur_reg  <= '0;
            voice_meta_reg <= '0;
            playing_reg    <= 1'b0;
            song_done_reg  <= 1'b0;
        end else begin
            voice_load_reg <= voice_load_next;
            song_done_reg  <= step && index_last;
            playing_reg    <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            if ((state_reg == ST_IDLE) && play) begin
                song_reg  <= song_sel;
                index_reg <= '0;
            end else if (step && (LOOP || !index_last)) begin
                index_reg <= index_reg + 1'b1;
            end
            if (load_note) begin
                voice_note_reg <= entry_note;
                voice_dur_reg  <= entry_dur;
                voice_meta_reg <= entry_meta;
                vptr_reg       <= vptr_next;
            end
        end
    end

    beat_counter u_beat_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (entry_dur),
        .beat     (cnt_beat),
        .hold     (!play),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    assign rom_addr   = {song_reg, index_reg};
    assign voice_load = voice_load_reg;
    assign voice_note = voice_note_reg;
    assign voice_dur  = voice_dur_reg;
    assign voice_meta = voice_meta_reg;
    assign playing    = playing_reg;
    assign song_done  = song_done_reg;

endmodule
